// File: rtl/logit_pair_feeder.sv
// logit_pair_feeder
// Collects output-neuron accumulator words, converts each to a 16-bit signed
// logit and presents them two at a time (IN1 even, IN2 odd) to the comparator
// stage with a one-cycle TRIG strobe. An odd final logit is paired with the
// most negative 16-bit value so the pad can never win a strict greater-than.
// Optional build macro: LOGIT_PAIR_FEEDER_SAT_EN -- when defined, accumulator
// values outside +/-32767 saturate to 16'h7FFF / 16'h8001; when undefined the
// logit is the low 16 bits of the accumulator.
module logit_pair_feeder #(
   parameter int NUM_CLASSES = 10
) (
   input  logic               CLKEXT,
   input  logic               RST_COMP,
   input  logic               START,
   input  logic               ACC_VALID,
   input  logic signed [23:0] ACC_IN,
   output logic               ACC_READY,
   output logic               EN_COMP,
   output logic               TRIG,
   output logic signed [15:0] IN1,
   output logic signed [15:0] IN2,
   output logic               BUSY,
   output logic               DONE
);

   localparam int ACC_W  = 24;
   localparam int DATA_W = 16;

   localparam logic [7:0]               LAST_CNT = 8'(NUM_CLASSES);
   // Most negative value: loses every strict signed compare, including ties.
   localparam logic signed [DATA_W-1:0] PAD      = 16'sh8000;

   typedef enum logic [2:0] {
      IDLE,
      COLLECT_A,
      COLLECT_B,
      FIRE,
      FINISH
   } state_t;

   state_t                    state_q,     state_d;
   logic [7:0]                count_q,     count_d;
   logic [7:0]                count_inc;
   logic signed [DATA_W-1:0]  in1_q,       in1_d;
   logic signed [DATA_W-1:0]  in2_q,       in2_d;
   logic                      trig_q,      trig_d;
   logic                      done_q,      done_d;
   logic                      acc_ready_q, acc_ready_d;
   logic                      busy_q,      busy_d;
   logic                      en_comp_q,   en_comp_d;
   logic signed [DATA_W-1:0]  logit;

`ifdef LOGIT_PAIR_FEEDER_SAT_EN
   // Clamp symmetric around zero so the pad value stays unique.
   function automatic logic signed [DATA_W-1:0] sat_logit(input logic signed [ACC_W-1:0] acc);
      if (acc > 24'sd32767) begin
         return 16'sh7FFF;
      end else if (acc < -24'sd32767) begin
         return 16'sh8001;
      end else begin
         return acc[DATA_W-1:0];
      end
   endfunction

   assign logit = sat_logit(ACC_IN);
`else
   logic acc_hi_unused;

   assign logit         = ACC_IN[DATA_W-1:0];
   assign acc_hi_unused = ^ACC_IN[ACC_W-1:DATA_W];
`endif

   assign count_inc = count_q + 8'd1;

   // Next-state, logit capture and registered-output decode.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      in1_d   = in1_q;
      in2_d   = in2_q;
      case (state_q)
         IDLE: begin
            if (START) begin
               count_d = 8'd0;
               state_d = COLLECT_A;
            end
         end
         COLLECT_A: begin
            if (ACC_VALID) begin
               in1_d   = logit;
               count_d = count_inc;
               if (count_inc == LAST_CNT) begin
                  in2_d   = PAD;
                  state_d = FIRE;
               end else begin
                  state_d = COLLECT_B;
               end
            end
         end
         COLLECT_B: begin
            if (ACC_VALID) begin
               in2_d   = logit;
               count_d = count_inc;
               state_d = FIRE;
            end
         end
         FIRE: begin
            state_d = (count_q == LAST_CNT) ? FINISH : COLLECT_A;
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      trig_d      = (state_d == FIRE);
      done_d      = (state_d == FINISH);
      acc_ready_d = (state_d == COLLECT_A) || (state_d == COLLECT_B);
      busy_d      = (state_d != IDLE);
      en_comp_d   = (state_d != IDLE);
   end

   // All state and outputs; reset returns to idle with pad on both logit outputs.
   always_ff @(posedge CLKEXT or posedge RST_COMP) begin
      if (RST_COMP) begin
         state_q     <= IDLE;
         count_q     <= 8'd0;
         in1_q       <= PAD;
         in2_q       <= PAD;
         trig_q      <= 1'b0;
         done_q      <= 1'b0;
         acc_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         en_comp_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         in1_q       <= in1_d;
         in2_q       <= in2_d;
         trig_q      <= trig_d;
         done_q      <= done_d;
         acc_ready_q <= acc_ready_d;
         busy_q      <= busy_d;
         en_comp_q   <= en_comp_d;
      end
   end

   assign ACC_READY = acc_ready_q;
   assign EN_COMP   = en_comp_q;
   assign TRIG      = trig_q;
   assign IN1       = in1_q;
   assign IN2       = in2_q;
   assign BUSY      = busy_q;
   assign DONE      = done_q;

endmodule

// File: tb/tb_logit_pair_feeder.sv
// tb_logit_pair_feeder
// Two feeders (10 and 3 classes) with independent stimulus. A transaction-level
// model predicts every output each cycle; directed scenarios add literal checks
// on strobe timing and logit pairs.
module tb_logit_pair_feeder;

   logic               CLKEXT = 1'b0;
   logic               rst    = 1'b1;
   logic               st  [2];
   logic               vl  [2];
   logic signed [23:0] ac  [2];
   logic               rdy [2];
   logic               en  [2];
   logic               trg [2];
   logic               bsy [2];
   logic               dn  [2];
   logic signed [15:0] i1  [2];
   logic signed [15:0] i2  [2];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int t0    = 0;

   always #5 CLKEXT = ~CLKEXT;

   logit_pair_feeder #(.NUM_CLASSES(10)) dut10 (
      .CLKEXT(CLKEXT), .RST_COMP(rst), .START(st[0]), .ACC_VALID(vl[0]), .ACC_IN(ac[0]),
      .ACC_READY(rdy[0]), .EN_COMP(en[0]), .TRIG(trg[0]), .IN1(i1[0]), .IN2(i2[0]),
      .BUSY(bsy[0]), .DONE(dn[0]));

   logit_pair_feeder #(.NUM_CLASSES(3)) dut3 (
      .CLKEXT(CLKEXT), .RST_COMP(rst), .START(st[1]), .ACC_VALID(vl[1]), .ACC_IN(ac[1]),
      .ACC_READY(rdy[1]), .EN_COMP(en[1]), .TRIG(trg[1]), .IN1(i1[1]), .IN2(i2[1]),
      .BUSY(bsy[1]), .DONE(dn[1]));

   always @(posedge CLKEXT) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int                 ncls  [2] = '{10, 3};
   int                 m_cnt [2];
   bit                 m_busy[2];
   bit                 m_rdy [2];
   bit                 m_trig[2];
   bit                 m_done[2];
   logic signed [15:0] m_in1 [2];
   logic signed [15:0] m_in2 [2];

   function automatic logic signed [15:0] conv(input logic signed [23:0] a);
`ifdef LOGIT_PAIR_FEEDER_SAT_EN
      if (a > 32767) return 16'sh7FFF;
      if (a < -32767) return 16'sh8001;
`endif
      return a[15:0];
   endfunction

   task automatic m_reset(input int k);
      m_cnt[k] = 0; m_busy[k] = 0; m_rdy[k] = 0; m_trig[k] = 0; m_done[k] = 0;
      m_in1[k] = 16'sh8000; m_in2[k] = 16'sh8000;
   endtask

   // One clock of the image protocol: idle -> collect logits -> strobe each
   // pair -> done pulse after the strobe that used the last logit.
   task automatic m_step(input int k);
      logic signed [15:0] v;
      if (!m_busy[k]) begin
         if (st[k]) begin m_busy[k] = 1; m_rdy[k] = 1; m_cnt[k] = 0; end
      end else if (m_trig[k]) begin
         m_trig[k] = 0;
         if (m_cnt[k] == ncls[k]) m_done[k] = 1; else m_rdy[k] = 1;
      end else if (m_done[k]) begin
         m_done[k] = 0; m_busy[k] = 0;
      end else if (vl[k]) begin
         v = conv(ac[k]);
         if (m_cnt[k] % 2 == 0) begin
            m_in1[k] = v;
            m_cnt[k]++;
            if (m_cnt[k] == ncls[k]) begin
               m_in2[k] = 16'sh8000; m_trig[k] = 1; m_rdy[k] = 0;
            end
         end else begin
            m_in2[k] = v;
            m_cnt[k]++;
            m_trig[k] = 1; m_rdy[k] = 0;
         end
      end
   endtask

   always @(posedge CLKEXT or posedge rst) begin
      if (rst) begin
         m_reset(0); m_reset(1);
      end else begin
         m_step(0); m_step(1);
      end
   end

   // ---------------- per-cycle compare + event logs ----------------
   int          t10[$];
   int          d10[$];
   logic [31:0] p10[$];
   int          t3[$];
   int          d3[$];
   logic [31:0] p3[$];
   string       nm [2] = '{"n10", "n3"};

   initial begin
      @(posedge CLKEXT);
      forever begin
         @(negedge CLKEXT);
         for (int k = 0; k < 2; k++) begin
            chk({nm[k], "_ready"}, 32'(rdy[k]), 32'(m_rdy[k]));
            chk({nm[k], "_en"},    32'(en[k]),  32'(m_busy[k]));
            chk({nm[k], "_busy"},  32'(bsy[k]), 32'(m_busy[k]));
            chk({nm[k], "_trig"},  32'(trg[k]), 32'(m_trig[k]));
            chk({nm[k], "_done"},  32'(dn[k]),  32'(m_done[k]));
            chk({nm[k], "_in1"},   32'(i1[k]),  32'(m_in1[k]));
            chk({nm[k], "_in2"},   32'(i2[k]),  32'(m_in2[k]));
         end
         if (trg[0] === 1'b1) begin t10.push_back(cyc - t0); p10.push_back({i1[0], i2[0]}); end
         if (dn[0] === 1'b1) d10.push_back(cyc - t0);
         if (trg[1] === 1'b1) begin t3.push_back(cyc - t0); p3.push_back({i1[1], i2[1]}); end
         if (dn[1] === 1'b1) d3.push_back(cyc - t0);
      end
   end

   // ---------------- stimulus helpers (called at a negedge) ----------------
   task automatic start(input int k);
      st[k] = 1'b1;
      t0    = cyc;
      @(negedge CLKEXT);
      st[k] = 1'b0;
   endtask

   task automatic send(input int k, input logic signed [23:0] v);
      int n = 0;
      ac[k] = v;
      vl[k] = 1'b1;
      while (rdy[k] !== 1'b1 && n < 50) begin @(negedge CLKEXT); n++; end
      chk("ready_seen", 32'(rdy[k]), 32'd1);
      @(negedge CLKEXT);
   endtask

   task automatic wait_done(input int k);
      int n = 0;
      while (dn[k] !== 1'b1 && n < 40) begin @(negedge CLKEXT); n++; end
      chk("done_seen", 32'(dn[k]), 32'd1);
      @(negedge CLKEXT);
      chk("busy_after_done", 32'(bsy[k]), 32'd0);
   endtask

   task automatic chk_reset_vals(input int k);
      chk("rst_ready", 32'(rdy[k]), 32'd0);
      chk("rst_en",    32'(en[k]),  32'd0);
      chk("rst_trig",  32'(trg[k]), 32'd0);
      chk("rst_busy",  32'(bsy[k]), 32'd0);
      chk("rst_done",  32'(dn[k]),  32'd0);
      chk("rst_in1",   32'({16'd0, i1[k]}), 32'h0000_8000);
      chk("rst_in2",   32'({16'd0, i2[k]}), 32'h0000_8000);
   endtask

   task automatic chk_ten_timing(input string tag);
      int exp_t[5] = '{3, 6, 9, 12, 15};
      chk({tag, "_trig_count"}, 32'(t10.size()), 32'd5);
      for (int j = 0; j < 5; j++)
         chk({tag, "_trig_t"}, (j < t10.size()) ? 32'(t10[j]) : 32'hFFFF_FFFF, 32'(exp_t[j]));
      chk({tag, "_done_t"}, (d10.size() > 0) ? 32'(d10[0]) : 32'hFFFF_FFFF, 32'd16);
   endtask

   function automatic logic [31:0] at10(input int j);
      return (j < p10.size()) ? p10[j] : 32'hxxxx_xxxx;
   endfunction

   // ---------------- directed scenarios ----------------
   initial begin
      for (int k = 0; k < 2; k++) begin st[k] = 1'b0; vl[k] = 1'b0; ac[k] = '0; end
      repeat (2) @(negedge CLKEXT);
      chk_reset_vals(0);
      chk_reset_vals(1);
      #2 rst = 1'b0;
      @(negedge CLKEXT);

      // Ten logits 0..9, continuous valid.
      t10.delete(); d10.delete(); p10.delete();
      start(0);
      for (int i = 0; i < 10; i++) send(0, 24'(i));
      vl[0] = 1'b0;
      wait_done(0);
      chk_ten_timing("plain");
      for (int j = 0; j < 5; j++)
         chk("plain_pair", at10(j), {16'(2 * j), 16'(2 * j + 1)});

      // START pulses mid-image must not disturb the sequence.
      @(negedge CLKEXT);
      t10.delete(); d10.delete(); p10.delete();
      start(0);
      for (int i = 0; i < 10; i++) begin
         if (i == 4 || i == 7) st[0] = 1'b1;
         send(0, 24'(i + 100));
         st[0] = 1'b0;
      end
      vl[0] = 1'b0;
      wait_done(0);
      chk_ten_timing("busy_start");
      chk("busy_start_pair0", at10(0), {16'd100, 16'd101});

      // Stall four cycles between logits 2 and 3.
      @(negedge CLKEXT);
      t10.delete(); d10.delete(); p10.delete();
      start(0);
      for (int i = 0; i < 3; i++) send(0, 24'(i));
      vl[0] = 1'b0;
      for (int j = 0; j < 4; j++) begin
         chk("stall_ready", 32'(rdy[0]), 32'd1);
         chk("stall_in1",   32'({16'd0, i1[0]}), 32'd2);
         chk("stall_trig",  32'(trg[0]), 32'd0);
         @(negedge CLKEXT);
      end
      chk("stall_trig_count_mid", 32'(t10.size()), 32'd1);
      for (int i = 3; i < 10; i++) send(0, 24'(i));
      vl[0] = 1'b0;
      wait_done(0);
      chk("stall_trig_count", 32'(t10.size()), 32'd5);
      chk("stall_pair1", at10(1), {16'd2, 16'd3});

      // Reset after the third transfer, then a fresh image.
      @(negedge CLKEXT);
      start(0);
      for (int i = 0; i < 3; i++) send(0, 24'(i + 40));
      t10.delete(); d10.delete(); p10.delete();
      #2 rst = 1'b1;
      #1 chk_reset_vals(0);
      @(negedge CLKEXT);
      #2 rst = 1'b0;
      @(negedge CLKEXT);
      chk("post_rst_trigs", 32'(t10.size()), 32'd0);
      start(0);
      for (int i = 0; i < 10; i++) send(0, 24'(i + 20));
      vl[0] = 1'b0;
      wait_done(0);
      chk_ten_timing("after_rst");
      chk("after_rst_pair0", at10(0), {16'd20, 16'd21});
      chk("after_rst_pair4", at10(4), {16'd28, 16'd29});

      // Out-of-range accumulator values.
      @(negedge CLKEXT);
      t10.delete(); d10.delete(); p10.delete();
      start(0);
      send(0, 24'sh010000); send(0, 24'shFF0000);
      send(0, 24'sh007FFF); send(0, 24'shFF8000);
      send(0, 24'shFF8001); send(0, 24'sh7FFFFF);
      send(0, 24'sh800000); send(0, 24'sd3);
      send(0, -24'sd1);     send(0, 24'sd5);
      vl[0] = 1'b0;
      wait_done(0);
`ifdef LOGIT_PAIR_FEEDER_SAT_EN
      chk("sat_pair0", at10(0), 32'h7FFF_8001);
      chk("sat_pair1", at10(1), 32'h7FFF_8001);
      chk("sat_pair2", at10(2), 32'h8001_7FFF);
`else
      chk("sat_pair0", at10(0), 32'h0000_0000);
      chk("sat_pair1", at10(1), 32'h7FFF_8000);
      chk("sat_pair2", at10(2), 32'h8001_FFFF);
`endif
      chk("sat_pair4", at10(4), 32'hFFFF_0005);

      // Three classes: odd count pads the last pair.
      @(negedge CLKEXT);
      t3.delete(); d3.delete(); p3.delete();
      start(1);
      send(1, 24'sd5); send(1, -24'sd2); send(1, 24'sd7);
      vl[1] = 1'b0;
      wait_done(1);
      chk("n3_trig_count", 32'(t3.size()), 32'd2);
      chk("n3_pair0", (p3.size() > 0) ? p3[0] : 32'hxxxx_xxxx, 32'h0005_FFFE);
      chk("n3_pair1", (p3.size() > 1) ? p3[1] : 32'hxxxx_xxxx, 32'h0007_8000);
      chk("n3_trig_t0", (t3.size() > 0) ? 32'(t3[0]) : 32'hFFFF_FFFF, 32'd3);
      chk("n3_done_gap", (t3.size() > 1 && d3.size() > 0) ? 32'(d3[0] - t3[1]) : 32'hFFFF_FFFF, 32'd1);

      repeat (2) @(negedge CLKEXT);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule

// File: doc/logit_pair_feeder.md
LOGIT_PAIR_FEEDER -- requirements
Module: logit_pair_feeder

Interface
REQ-001 Parameter NUM_CLASSES, default 10, SHALL set the logits per image; legal range 2..254.
REQ-002 CLKEXT  input  1  clock; all state SHALL update on the rising edge.
REQ-003 RST_COMP  input  1  asynchronous, active-high reset.
REQ-004 START  input  1  single-cycle request to begin one image.
REQ-005 ACC_VALID  input  1  output-neuron accumulator word valid.
REQ-006 ACC_IN  input  24  signed output-neuron accumulator value.
REQ-007 ACC_READY  output  1  feeder accepts ACC_IN this cycle.
REQ-008 EN_COMP  output  1  comparator enable, to comparator stage.
REQ-009 TRIG  output  1  one-cycle compare strobe, to comparator stage.
REQ-010 IN1  output  16  signed logit, even position, to comparator stage.
REQ-011 IN2  output  16  signed logit, odd position, to comparator stage.
REQ-012 BUSY  output  1  high whenever state is not IDLE.
REQ-013 DONE  output  1  one-cycle pulse after the last pair has been strobed.

Function
REQ-014 All outputs SHALL be registered; the FSM SHALL use states IDLE, COLLECT_A, COLLECT_B, FIRE and FINISH.
REQ-015 IDLE: START=1 SHALL clear the 8-bit logit count and enter COLLECT_A; START in any other state SHALL be ignored.
REQ-016 ACC_READY SHALL be 1 only in COLLECT_A and COLLECT_B; a transfer occurs on ACC_VALID=1 and ACC_READY=1 at the same clock edge.
REQ-017 COLLECT_A transfer: load the converted logit into IN1 and increment the count; if the count then equals NUM_CLASSES, load IN2 with 16'h8000 (pad) and go to FIRE, else go to COLLECT_B.
REQ-018 COLLECT_B transfer: load the converted logit into IN2, increment the count, go to FIRE.
REQ-019 FIRE: TRIG=1 for exactly that cycle, with IN1/IN2 held stable; next state is FINISH if count equals NUM_CLASSES, else COLLECT_A.
REQ-020 FINISH: DONE=1 for exactly that cycle; next state is IDLE.
REQ-021 EN_COMP SHALL be 1 in every state except IDLE.
REQ-022 The pad 16'h8000 SHALL never win a strict signed greater-than comparison against the comparator's initial value.
REQ-023 With ACC_VALID held high and NUM_CLASSES=10, START at cycle t0 SHALL yield TRIG at t3, t6, t9, t12 and t15, and DONE at t16.
REQ-024 ACC_VALID low SHALL stall COLLECT_A/COLLECT_B indefinitely, without timeout, and SHALL not alter any output.
REQ-025 IN1 and IN2 SHALL change only on a transfer or a pad load.

Reset
REQ-026 RST_COMP=1 SHALL immediately force IDLE, count=0, IN1=IN2=16'h8000, and TRIG, EN_COMP, ACC_READY, BUSY, DONE = 0.
REQ-027 Reset asserted mid-image SHALL abandon the image; no TRIG or DONE SHALL follow until a new START after reset release.

Configuration
REQ-028 Macro LOGIT_PAIR_FEEDER_SAT_EN defined: the logit SHALL be ACC_IN saturated to 16'h7FFF when above +32767, and to 16'h8001 when below -32767.
REQ-029 Macro LOGIT_PAIR_FEEDER_SAT_EN undefined: the logit SHALL be ACC_IN[15:0] truncated, with no saturation logic synthesized.

Verification
REQ-030 Reset, START, 10 logits 0..9 with ACC_VALID continuous -> pairs (0,1),(2,3),(4,5),(6,7),(8,9); TRIG at t3..t15 step 3; DONE at t16; BUSY low at t17.
REQ-031 NUM_CLASSES=3, logits 5,-2,7 -> pair (5,-2), then pair (7,16'h8000); DONE the cycle after the second TRIG.
REQ-032 ACC_VALID low for 4 cycles between logits 2 and 3 -> ACC_READY stays high, no TRIG until logit 3 transfers, IN1=2 held unchanged.
REQ-033 ACC_IN=24'h010000 and 24'hFF0000 with SAT_EN defined -> 16'h7FFF and 16'h8001; with SAT_EN undefined -> 16'h0000 and 16'h0000.
REQ-034 RST_COMP pulsed after the third transfer, then START -> outputs return to reset values; the new image restarts at count 0; exactly 5 TRIGs follow.
REQ-035 START asserted while BUSY=1 -> ignored; the TRIG/DONE sequence is identical to that of an undisturbed run.
